// File: rtl/vocab_writer.sv
// Vocabulary SRAM writer: accepts packed words over valid/ready and stores each
// as a null-terminated character string at consecutive SRAM addresses from 0.
module vocab_writer #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WORD_LENGTH = 3,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   word,
  input  logic                                word_valid,
  output logic                                word_ready,
  output logic                                sram_cs,
  output logic                                sram_we,
  output logic [ADDR_WIDTH-1:0]               sram_addr,
  output logic [DATA_WIDTH-1:0]               sram_din,
  output logic [ADDR_WIDTH:0]                 fill,
  output logic [ADDR_WIDTH-1:0]               word_count,
  output logic                                full,
  output logic                                overflow
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned WORD_W = WORD_LENGTH * DATA_WIDTH;
  localparam int unsigned IDX_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int unsigned LEN_W  = $clog2(WORD_LENGTH + 1);
  localparam int unsigned FILL_W = ADDR_WIDTH + 1;
  localparam int unsigned SUM_W  = FILL_W + LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    TERM  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic [LEN_W-1:0]        len_c;
  logic                    stop_c;
  logic [SUM_W-1:0]        need_c;
  logic                    no_room_c;
  logic                    accept_c;
  logic [DATA_WIDTH-1:0]   char_c;

  // Word length: characters before the first zero, capped at WORD_LENGTH.
  always_comb begin
    len_c  = '0;
    stop_c = 1'b0;
    for (int i = 0; i < int'(WORD_LENGTH); i++) begin
      if (!stop_c && (word[i*DATA_WIDTH +: DATA_WIDTH] != '0)) begin
        len_c = LEN_W'(i + 1);
      end else begin
        stop_c = 1'b1;
      end
    end
  end

  // Select the character currently being written from the captured word.
  always_comb begin
    char_c = '0;
    for (int i = 0; i < int'(WORD_LENGTH); i++) begin
      if (idx_q == IDX_W'(i)) begin
        char_c = word_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign full       = (fill_q >= FILL_W'(DEPTH - 1));
  assign word_ready = (state_q == IDLE) && !full;
  assign accept_c   = word_valid && word_ready;
  assign need_c     = SUM_W'(fill_q) + SUM_W'(len_c) + SUM_W'(1);
  assign no_room_c  = (need_c > SUM_W'(DEPTH));

  assign fill       = fill_q;
  assign word_count = count_q;
  assign overflow   = overflow_q;

  // Next-state and SRAM port decode; the port depends on registered state only.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    len_d      = len_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          word_d = word;
          len_d  = len_c;
          if (len_c == '0) begin
            state_d = IDLE;
          end else if (no_room_c) begin
            overflow_d = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = fill_q[ADDR_WIDTH-1:0];
        sram_din  = char_c;
        fill_d    = fill_q + FILL_W'(1);
        idx_d     = idx_q + IDX_W'(1);
        if ((LEN_W'(idx_q) + LEN_W'(1)) == len_q) begin
          state_d = TERM;
        end
      end
      TERM: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = fill_q[ADDR_WIDTH-1:0];
        sram_din  = '0;
        fill_d    = fill_q + FILL_W'(1);
        count_d   = count_q + ADDR_WIDTH'(1);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_vocab_writer.sv
// Self-checking bench for vocab_writer: directed scenarios plus random words
// checked against a queue/array model of the expected SRAM layout.
module tb_vocab_writer;

  localparam int unsigned AW    = 4;
  localparam int unsigned WL    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = WL * DW;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [WW-1:0] CAT = 24'h746163;
  localparam logic [WW-1:0] HI  = 24'h006968;
  localparam logic [WW-1:0] A1  = 24'h000061;
  localparam logic [WW-1:0] B1  = 24'h000062;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] word;
  logic          word_valid;
  logic          word_ready;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [AW:0]   fill;
  logic [AW-1:0] word_count;
  logic          full;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected SRAM contents and counters.
  int            m_fill;
  int            m_count;
  logic [DW-1:0] m_mem [DEPTH];
  logic [11:0]   exp_wr [$];

  // Observed writes.
  logic [11:0]   obs_wr [$];
  int            obs_cyc [$];
  logic [DW-1:0] tb_mem [DEPTH];
  int            cyc = 0;

  vocab_writer #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .fill       (fill),
    .word_count (word_count),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (sram_cs && sram_we) begin
      obs_wr.push_back({sram_addr, sram_din});
      obs_cyc.push_back(cyc);
      tb_mem[sram_addr] = sram_din;
    end
  end

  task automatic model_clear();
    m_fill  = 0;
    m_count = 0;
    for (int a = 0; a < int'(DEPTH); a++) m_mem[a] = 8'h00;
  endtask

  // Appends the word's expected writes to exp_wr and updates the model.
  task automatic model_word(input logic [WW-1:0] w, output int exp_busy, output int exp_ovf);
    int l;
    l = 0;
    while (l < int'(WL) && w[l*DW +: DW] != 8'h00) l++;
    exp_busy = 0;
    exp_ovf  = 0;
    if (l == 0) return;
    if (m_fill + l + 1 > int'(DEPTH)) begin
      exp_ovf = 1;
      return;
    end
    for (int k = 0; k <= l; k++) begin
      m_mem[m_fill] = (k < l) ? w[k*DW +: DW] : 8'h00;
      exp_wr.push_back({4'(m_fill), m_mem[m_fill]});
      m_fill++;
    end
    m_count++;
    exp_busy = l + 1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    word       = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Presents one word for a single accepted cycle; reports busy cycles and overflow pulses.
  task automatic send_word(input logic [WW-1:0] w, output int busy, output int ovf_n);
    int n;
    obs_wr.delete();
    obs_cyc.delete();
    n = 0;
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (word_ready !== 1'b1) $display("FAIL ready_timeout: word_ready=%b want 1", word_ready);
    else n_pass++;
    word       = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    word       = WW'($urandom);
    busy  = 0;
    ovf_n = 0;
    while (!word_ready && !(full && !sram_we) && busy < 20) begin
      ovf_n += int'(overflow);
      busy++;
      @(negedge clk);
    end
    ovf_n += int'(overflow);
    @(negedge clk);
    ovf_n += int'(overflow);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (word_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", word_ready);
    else n_pass++;
    n_checks++;
    if (fill !== 5'd0 || word_count !== 4'd0) $display("FAIL reset_counts: fill=%0d count=%0d want 0 0", fill, word_count);
    else n_pass++;
    n_checks++;
    if ({sram_cs, sram_we, sram_addr, sram_din} !== 14'd0)
      $display("FAIL reset_port: cs=%b we=%b addr=%0d din=%h want all 0", sram_cs, sram_we, sram_addr, sram_din);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0 || full !== 1'b0) $display("FAIL reset_flags: overflow=%b full=%b want 0 0", overflow, full);
    else n_pass++;
  endtask

  task automatic test_store_and_empty();
    logic [WW-1:0] words [4];
    string         tags [4];
    int eb, eo, ob, oo, nbad;
    words = '{CAT, HI, 24'h000000, 24'h410000};
    tags  = '{"cat", "hi", "empty0", "empty_lead0"};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_wr.delete();
      model_word(words[i], eb, eo);
      send_word(words[i], ob, oo);
      nbad = (obs_wr.size() == exp_wr.size()) ? 0 : 1;
      foreach (exp_wr[k]) if (k < obs_wr.size() && obs_wr[k] !== exp_wr[k]) nbad++;
      n_checks++;
      if (nbad !== 0) $display("FAIL %s_writes: got %0d writes (%0d bad) want %0d", tags[i], obs_wr.size(), nbad, exp_wr.size());
      else n_pass++;
      n_checks++;
      if (ob !== eb) $display("FAIL %s_busy: ready low %0d cycles want %0d", tags[i], ob, eb);
      else n_pass++;
      n_checks++;
      if (oo !== eo) $display("FAIL %s_overflow: %0d pulse cycles want %0d", tags[i], oo, eo);
      else n_pass++;
      n_checks++;
      if (fill !== 5'(m_fill) || word_count !== 4'(m_count))
        $display("FAIL %s_counts: fill=%0d count=%0d want %0d %0d", tags[i], fill, word_count, m_fill, m_count);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [WW-1:0] words [6];
    int eb, eo, ob, oo, nbad;
    words = '{CAT, CAT, CAT, A1, CAT, B1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_wr.delete();
      model_word(words[i], eb, eo);
      send_word(words[i], ob, oo);
      nbad = (obs_wr.size() == exp_wr.size()) ? 0 : 1;
      foreach (exp_wr[k]) if (k < obs_wr.size() && obs_wr[k] !== exp_wr[k]) nbad++;
      n_checks++;
      if (nbad !== 0) $display("FAIL ovf%0d_writes: got %0d writes (%0d bad) want %0d", i, obs_wr.size(), nbad, exp_wr.size());
      else n_pass++;
      n_checks++;
      if (ob !== eb) $display("FAIL ovf%0d_busy: ready low %0d cycles want %0d", i, ob, eb);
      else n_pass++;
      n_checks++;
      if (oo !== eo) $display("FAIL ovf%0d_pulse: %0d pulse cycles want %0d", i, oo, eo);
      else n_pass++;
      n_checks++;
      if (fill !== 5'(m_fill) || word_count !== 4'(m_count))
        $display("FAIL ovf%0d_counts: fill=%0d count=%0d want %0d %0d", i, fill, word_count, m_fill, m_count);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (word_ready !== 1'b1) $display("FAIL ovf_ready_after_drop: got %b want 1", word_ready);
        else n_pass++;
      end
    end
    n_checks++;
    if (full !== 1'b1 || word_ready !== 1'b0) $display("FAIL full_at_end: full=%b ready=%b want 1 0", full, word_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int eb, eo, ob, oo, nbad;
    do_reset();
    word       = CAT;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sram_we !== 1'b1 || sram_addr !== 4'd1) $display("FAIL mid_second_write: we=%b addr=%0d want 1 1", sram_we, sram_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sram_cs !== 1'b0 || sram_we !== 1'b0) $display("FAIL mid_port_idle: cs=%b we=%b want 0 0", sram_cs, sram_we);
    else n_pass++;
    n_checks++;
    if (fill !== 5'd0 || word_count !== 4'd0) $display("FAIL mid_counts: fill=%0d count=%0d want 0 0", fill, word_count);
    else n_pass++;
    rst = 1'b0;
    model_clear();
    exp_wr.delete();
    model_word(HI, eb, eo);
    send_word(HI, ob, oo);
    nbad = (obs_wr.size() == exp_wr.size()) ? 0 : 1;
    foreach (exp_wr[k]) if (k < obs_wr.size() && obs_wr[k] !== exp_wr[k]) nbad++;
    n_checks++;
    if (nbad !== 0) $display("FAIL mid_hi_writes: got %0d writes (%0d bad) want %0d", obs_wr.size(), nbad, exp_wr.size());
    else n_pass++;
    n_checks++;
    if (fill !== 5'(m_fill) || word_count !== 4'(m_count))
      $display("FAIL mid_hi_counts: fill=%0d count=%0d want %0d %0d", fill, word_count, m_fill, m_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int eb, eo, n, nbad;
    do_reset();
    exp_wr.delete();
    model_word(CAT, eb, eo);
    model_word(HI, eb, eo);
    obs_wr.delete();
    obs_cyc.delete();
    word       = CAT;
    word_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!word_ready && n < 20) begin
      word = WW'($urandom);
      n++;
      @(negedge clk);
    end
    word = HI;
    @(negedge clk);
    word_valid = 1'b0;
    for (int i = 0; i < 20 && !word_ready; i++) @(negedge clk);
    n_checks++;
    if (n !== 4) $display("FAIL hold_ready_low: %0d cycles want 4", n);
    else n_pass++;
    nbad = (obs_wr.size() == exp_wr.size()) ? 0 : 1;
    foreach (exp_wr[k]) if (k < obs_wr.size() && obs_wr[k] !== exp_wr[k]) nbad++;
    n_checks++;
    if (nbad !== 0) $display("FAIL hold_writes: got %0d writes (%0d bad) want %0d", obs_wr.size(), nbad, exp_wr.size());
    else n_pass++;
    n_checks++;
    if (obs_cyc.size() < 5) $display("FAIL hold_spacing: only %0d writes want 7", obs_cyc.size());
    else if (obs_cyc[4] - obs_cyc[0] !== 5) $display("FAIL hold_spacing: %0d cycles between words want 5", obs_cyc[4] - obs_cyc[0]);
    else n_pass++;
    n_checks++;
    if (fill !== 5'(m_fill) || word_count !== 4'(m_count))
      $display("FAIL hold_counts: fill=%0d count=%0d want %0d %0d", fill, word_count, m_fill, m_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WW-1:0] w;
    int l, eb, eo, ob, oo, nbad;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (m_fill >= int'(DEPTH) - 1) break;
      l = $urandom_range(0, 3);
      w = '0;
      for (int k = 0; k < int'(WL); k++) begin
        if (k < l) w[k*DW +: DW] = 8'($urandom_range(1, 255));
        else if (k > l) w[k*DW +: DW] = 8'($urandom);
      end
      exp_wr.delete();
      model_word(w, eb, eo);
      send_word(w, ob, oo);
      nbad = (obs_wr.size() == exp_wr.size()) ? 0 : 1;
      foreach (exp_wr[k]) if (k < obs_wr.size() && obs_wr[k] !== exp_wr[k]) nbad++;
      n_checks++;
      if (nbad !== 0) $display("FAIL rnd%0d_writes: word %h got %0d writes (%0d bad) want %0d", i, w, obs_wr.size(), nbad, exp_wr.size());
      else n_pass++;
      n_checks++;
      if (ob !== eb || oo !== eo) $display("FAIL rnd%0d_timing: word %h busy=%0d ovf=%0d want %0d %0d", i, w, ob, oo, eb, eo);
      else n_pass++;
      n_checks++;
      if (fill !== 5'(m_fill) || word_count !== 4'(m_count))
        $display("FAIL rnd%0d_counts: fill=%0d count=%0d want %0d %0d", i, fill, word_count, m_fill, m_count);
      else n_pass++;
    end
    nbad = 0;
    for (int a = 0; a < m_fill; a++) if (tb_mem[a] !== m_mem[a]) nbad++;
    n_checks++;
    if (nbad !== 0) $display("FAIL rnd_memory: %0d bad entries of %0d want 0", nbad, m_fill);
    else n_pass++;
    n_checks++;
    if (full !== (m_fill >= int'(DEPTH) - 1) || word_ready !== !(m_fill >= int'(DEPTH) - 1))
      $display("FAIL rnd_full: full=%b ready=%b fill_model=%0d", full, word_ready, m_fill);
    else n_pass++;
  endtask

  initial begin
    rst        = 1'b1;
    word_valid = 1'b0;
    word       = '0;
    test_reset();
    test_store_and_empty();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
